// File: rtl/frame_writer.sv
// frame_writer: streams a raster frame (or a zero fill) into a RAM via registered write port.
module frame_writer #(
  parameter int XSZ    = 3,
  parameter int YSZ    = 3,
  parameter int ADDRSZ = 6,
  parameter int COLSZ  = 3,
  parameter int WIDTH  = 6,
  parameter int HEIGHT = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              clear,
  input  logic [COLSZ-1:0]  pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [ADDRSZ-1:0] wr_address,
  output logic [COLSZ-1:0]  wr_data,
  output logic              wren,
  output logic              busy,
  output logic              frame_done,
  output logic              frameLoaded
);
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, DONE} state_t;
  state_t              state_q;
  logic [XSZ-1:0]      x_q;
  logic [YSZ-1:0]      y_q;
  logic                pix_ready_q, wren_q, frame_done_q, frame_loaded_q;
  logic [ADDRSZ-1:0]   wr_address_q, addr_d;
  logic [COLSZ-1:0]    wr_data_q;
  logic                x_last, y_last, step_d;
  assign x_last = x_q == XSZ'(WIDTH - 1);
  assign y_last = y_q == YSZ'(HEIGHT - 1);
  assign addr_d = ADDRSZ'(y_q) * ADDRSZ'(WIDTH) + ADDRSZ'(x_q);
  // CLEAR writes every cycle; WRITE only on an accepted handshake
  assign step_d = (state_q == CLEAR) || (state_q == WRITE && pix_valid && pix_ready_q);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      pix_ready_q    <= 1'b0;
      wren_q         <= 1'b0;
      wr_address_q   <= '0;
      wr_data_q      <= '0;
      frame_done_q   <= 1'b0;
      frame_loaded_q <= 1'b0;
    end else begin
      wren_q       <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: if (start || clear) begin
          state_q        <= start ? WRITE : CLEAR;
          pix_ready_q    <= start;
          x_q            <= '0;
          y_q            <= '0;
          frame_loaded_q <= 1'b0;
        end
        WRITE, CLEAR: if (step_d) begin
          wren_q       <= 1'b1;
          wr_address_q <= addr_d;
          wr_data_q    <= state_q == WRITE ? pix_in : '0;
          x_q          <= x_last ? '0 : x_q + 1'b1;
          if (x_last) y_q <= y_last ? '0 : y_q + 1'b1;
          if (x_last && y_last) begin
            state_q      <= DONE;
            pix_ready_q  <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q        <= IDLE;
          frame_loaded_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign pix_ready   = pix_ready_q;
  assign wr_address  = wr_address_q;
  assign wr_data     = wr_data_q;
  assign wren        = wren_q;
  assign busy        = state_q != IDLE;
  assign frame_done  = frame_done_q;
  assign frameLoaded = frame_loaded_q;
endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed stimulus with a queue scoreboard checking every RAM write.
module tb_frame_writer;
  logic       clk = 1'b0, resetn = 1'b0, start = 1'b0, clear = 1'b0, pix_valid = 1'b0;
  logic [2:0] pix_in = '0;
  logic       pix_ready, wren, busy, frame_done, frameLoaded;
  logic [5:0] wr_address;
  logic [2:0] wr_data;
  int checks = 0, failures = 0;
  typedef struct {logic [5:0] a; logic [2:0] d; logic f;} exp_t;
  exp_t q[$];
  frame_writer dut (
    .clk(clk), .resetn(resetn), .start(start), .clear(clear), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .wr_address(wr_address),
    .wr_data(wr_data), .wren(wren), .busy(busy), .frame_done(frame_done),
    .frameLoaded(frameLoaded)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic push(input int a, input int d);
    exp_t e;
    e.a = 6'(a);
    e.d = 3'(d);
    e.f = (a == 35);
    q.push_back(e);
  endtask
  task automatic wait_empty(input string n);
    for (int i = 0; i < 60 && q.size() > 0; i++) tick();
    chk(n, q.size(), 0);
  endtask
  task automatic chk_zero(input string n);
    chk(n, {pix_ready, wren, wr_address, wr_data, busy, frame_done, frameLoaded}, 0);
  endtask
  always @(negedge clk) begin
    if (resetn && (wren || frame_done)) begin
      checks++;
      if (!wren || q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: wren=%0b frame_done=%0b addr=%0d data=%0d", wren, frame_done, wr_address, wr_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({wr_address, wr_data, frame_done} !== {e.a, e.d, e.f}) begin
          failures++;
          $display("FAIL sb_write: got addr=%0d data=%0d done=%0b expected addr=%0d data=%0d done=%0b",
                   wr_address, wr_data, frame_done, e.a, e.d, e.f);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    #3 chk_zero("reset_outputs");
    tick();
    resetn = 1'b1;
    chk("idle_busy", busy, 0);
    // back-to-back frame, stray start mid-frame
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("write_ready", pix_ready, 1);
    chk("write_busy", busy, 1);
    for (int i = 0; i < 36; i++) begin
      pix_valid = 1'b1;
      pix_in = 3'(i % 8);
      start = (i == 5);
      push(i, i % 8);
      tick();
      chk("b2b_wren", wren, 1);
    end
    pix_valid = 1'b0;
    start = 1'b0;
    chk("done_ready_low", pix_ready, 0);
    chk("done_not_loaded", frameLoaded, 0);
    tick();
    chk("loaded", frameLoaded, 1);
    chk("loaded_idle", busy, 0);
    wait_empty("b2b_empty");
    // pix_valid toggling
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 36; i++) begin
      pix_valid = 1'b1;
      pix_in = 3'((i * 3) % 8);
      push(i, (i * 3) % 8);
      tick();
      pix_valid = 1'b0;
      pix_in = 3'd7;
      chk("gap_wren_hi", wren, 1);
      tick();
      if (i < 35) chk("gap_wren_lo", wren, 0);
    end
    chk("gap_loaded", frameLoaded, 1);
    wait_empty("gap_empty");
    // clear fill
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_not_loaded", frameLoaded, 0);
    for (int i = 0; i < 36; i++) push(i, 0);
    for (int i = 0; i < 38; i++) begin
      chk("clear_ready_low", pix_ready, 0);
      tick();
    end
    chk("clear_loaded", frameLoaded, 1);
    wait_empty("clear_empty");
    // start+clear together, then reset after 10 beats
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    chk("prio_ready", pix_ready, 1);
    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'b1;
      pix_in = 3'(7 - i % 8);
      push(i, 7 - i % 8);
      tick();
    end
    pix_in = 3'd1;
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1 chk_zero("midframe_reset");
    pix_valid = 1'b0;
    tick();
    tick();
    chk_zero("held_reset");
    resetn = 1'b1;
    chk("reset_sb_empty", q.size(), 0);
    tick();
    chk("no_write_after_reset", wren, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 36; i++) begin
      pix_valid = 1'b1;
      pix_in = 3'((i ^ 5) % 8);
      push(i, (i ^ 5) % 8);
      tick();
    end
    pix_valid = 1'b0;
    tick();
    chk("restart_loaded", frameLoaded, 1);
    wait_empty("restart_empty");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
